password_entry_fsm: RTL and testbench

- Upstream stage of the password checker's output demux.
- Collects ASCII characters over a valid/ready handshake and compares the entered string against a parameterised stored password on an enter strobe.
- Emits one result byte plus a route select: sel=0 for the grant path, sel=1 for the deny path.
- Tracks consecutive failures; can lock out entry after repeated failures (optional feature).

---
 rtl/password_entry_fsm_if.sv | 36 +++
 rtl/password_entry_fsm.sv | 177 +++++++++++++++++
 tb/tb_password_entry_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/password_entry_fsm_if.sv
// -----------------------------------------------------------------------------
// password_entry_fsm_if
// Handshake bundle between a character source / result consumer and the
// password entry FSM.
//   char_in    [7:0]  ASCII character from the source
//   char_valid        char_in valid
//   char_ready        FSM accepts a character this cycle
//   enter             submit strobe
//   data_out   [7:0]  result byte ('O' grant, 'X' deny)
//   sel               demux select: 0 grant path, 1 deny path
//   out_valid         one-cycle pulse qualifying data_out/sel
//   fail_count [2:0]  consecutive failure count
//   locked            lockout active
// Modports: master = source/consumer side, slave = FSM side.
// -----------------------------------------------------------------------------
interface password_entry_fsm_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       enter;
    logic [7:0] data_out;
    logic       sel;
    logic       out_valid;
    logic [2:0] fail_count;
    logic       locked;

    modport master (
        output char_in, char_valid, enter,
        input  char_ready, data_out, sel, out_valid, fail_count, locked
    );

    modport slave (
        input  char_in, char_valid, enter,
        output char_ready, data_out, sel, out_valid, fail_count, locked
    );
endinterface

// File: rtl/password_entry_fsm.sv
// -----------------------------------------------------------------------------
// password_entry_fsm
// Collects ASCII characters over a valid/ready handshake and, on an enter
// strobe, compares them against a stored password. Produces one result byte
// plus a demux select for the downstream grant/deny paths and tracks
// consecutive failures.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   password_entry_fsm_if.slave (char_in/char_valid/char_ready/enter in,
//         data_out/sel/out_valid/fail_count/locked out)
//
// Optional build macro: PASSWORD_LOCKOUT_EN
//   defined   -> reaching MAX_FAILS failures locks entry for LOCK_CYCLES cycles
//   undefined -> fail_count saturates at MAX_FAILS, locked tied low
// -----------------------------------------------------------------------------
module password_entry_fsm #(
    parameter int          PW_LEN      = 4,
    parameter logic [63:0] PASSWORD    = 64'h0000_0000_3132_3334,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCK_CYCLES = 16
) (
    input logic                  clk,
    input logic                  rst,
    password_entry_fsm_if.slave  bus
);

    localparam logic [3:0] PW_LEN_C    = 4'(PW_LEN);
    localparam logic [2:0] MAX_FAILS_C = 3'(MAX_FAILS);

`ifdef PASSWORD_LOCKOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CHECK, S_RESULT, S_LOCK} state_t;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CHECK, S_RESULT} state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovl_q, ovl_d;
    logic [7:0]  data_q, data_d;
    logic        sel_q, sel_d;
    logic [2:0]  fail_q, fail_d;
    logic        char_ready_q, char_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        locked_q, locked_d;
    logic        accept;
    logic        match;

    assign accept = bus.char_valid && char_ready_q;

    // Only the low PW_LEN bytes of the buffer ever receive characters, so the
    // compare looks at that slice; overlong entries are caught via ovl_q.
    assign match = (cnt_q == PW_LEN_C) && !ovl_q &&
                   (buf_q[8*PW_LEN-1:0] == PASSWORD[8*PW_LEN-1:0]);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        ovl_d      = ovl_q;
        data_d     = data_q;
        sel_d      = sel_q;
        fail_d     = fail_q;
`ifdef PASSWORD_LOCKOUT_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (accept) begin
                    if (cnt_q < PW_LEN_C) begin
                        buf_d = {buf_q[55:0], bus.char_in};
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        ovl_d = 1'b1;
                    end
                    state_d = S_COLLECT;
                end
                // A character accepted alongside enter is already in buf_d,
                // so it takes part in the compare next cycle.
                if (bus.enter) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Result fields are registered here so they are stable for
                // the whole out_valid cycle.
                if (match) begin
                    data_d = 8'h4F;
                    sel_d  = 1'b0;
                    fail_d = 3'd0;
                end else begin
                    data_d = 8'h58;
                    sel_d  = 1'b1;
                    fail_d = (fail_q >= MAX_FAILS_C) ? fail_q : fail_q + 3'd1;
                end
                state_d = S_RESULT;
            end
            S_RESULT: begin
                buf_d   = '0;
                cnt_d   = '0;
                ovl_d   = 1'b0;
                state_d = S_IDLE;
`ifdef PASSWORD_LOCKOUT_EN
                if (sel_q && (fail_q == MAX_FAILS_C)) begin
                    state_d    = S_LOCK;
                    lock_cnt_d = LOCK_W'(LOCK_CYCLES - 1);
                end
`endif
            end
`ifdef PASSWORD_LOCKOUT_EN
            S_LOCK: begin
                if (lock_cnt_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = 3'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so that they
        // read 0 throughout reset and rise one cycle after release.
        char_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
        out_valid_d  = (state_d == S_RESULT);
`ifdef PASSWORD_LOCKOUT_EN
        locked_d     = (state_d == S_LOCK);
`else
        locked_d     = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            ovl_q        <= 1'b0;
            data_q       <= 8'h00;
            sel_q        <= 1'b0;
            fail_q       <= 3'd0;
            char_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
`ifdef PASSWORD_LOCKOUT_EN
            lock_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            ovl_q        <= ovl_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            fail_q       <= fail_d;
            char_ready_q <= char_ready_d;
            out_valid_q  <= out_valid_d;
            locked_q     <= locked_d;
`ifdef PASSWORD_LOCKOUT_EN
            lock_cnt_q   <= lock_cnt_d;
`endif
        end
    end

    assign bus.char_ready = char_ready_q;
    assign bus.data_out   = data_q;
    assign bus.sel        = sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fail_count = fail_q;
    assign bus.locked     = locked_q;

endmodule

// File: tb/tb_password_entry_fsm.sv
// -----------------------------------------------------------------------------
// tb_password_entry_fsm
// Directed, table-driven bench for password_entry_fsm with default parameters
// (PW_LEN=4, password "1234", MAX_FAILS=3, LOCK_CYCLES=16). Follows the
// PASSWORD_LOCKOUT_EN macro for the lockout section.
// -----------------------------------------------------------------------------
module tb_password_entry_fsm;

    logic clk = 1'b0;
    logic rst;

    password_entry_fsm_if bus ();

    password_entry_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [63:0] chars;    // right-aligned, first character most significant
        int          n;        // number of characters
        bit          same;     // enter asserted with the last character
        logic [7:0]  exp_data;
        bit          exp_sel;
        logic [2:0]  exp_fc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the characters and enter, then checks latency and the result.
    // Returns #1 after the edge that raises out_valid.
    task automatic do_entry(input vec_t v, input string tag);
        for (int i = v.n - 1; i >= 0; i--) begin
            logic [63:0] tmp;
            tmp            = v.chars >> (8 * i);
            bus.char_in    = tmp[7:0];
            bus.char_valid = 1'b1;
            bus.enter      = (i == 0) && v.same;
            tick();
        end
        bus.char_valid = 1'b0;
        if (!v.same || v.n == 0) begin
            bus.enter = 1'b1;
            tick();
        end
        bus.enter = 1'b0;
        chk({tag, "_ov_check_cycle"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_ready_check_cycle"}, 64'(bus.char_ready), 64'd0);
        tick();
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, 64'(bus.data_out), 64'(v.exp_data));
        chk({tag, "_sel"}, 64'(bus.sel), 64'(v.exp_sel));
        chk({tag, "_fail_count"}, 64'(bus.fail_count), 64'(v.exp_fc));
        chk({tag, "_locked"}, 64'(bus.locked), 64'd0);
    endtask

    initial begin
        vec_t w;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.enter      = 1'b0;
        rst            = 1'b1;

        vecs[0] = '{64'h31323334,   4, 1'b0, 8'h4F, 1'b0, 3'd0}; // correct
        vecs[1] = '{64'h31323335,   4, 1'b0, 8'h58, 1'b1, 3'd1}; // wrong last char
        vecs[2] = '{64'h31323334,   4, 1'b0, 8'h4F, 1'b0, 3'd0}; // correct clears count
        vecs[3] = '{64'h3132333435, 5, 1'b0, 8'h58, 1'b1, 3'd1}; // overlong
        vecs[4] = '{64'h31323334,   4, 1'b0, 8'h4F, 1'b0, 3'd0};
        vecs[5] = '{64'h313233,     3, 1'b0, 8'h58, 1'b1, 3'd1}; // short
        vecs[6] = '{64'h0,          0, 1'b0, 8'h58, 1'b1, 3'd2}; // bare enter
        vecs[7] = '{64'h31323334,   4, 1'b1, 8'h4F, 1'b0, 3'd0}; // '4' with enter

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_char_ready", 64'(bus.char_ready), 64'd0);
        chk("rst_data_out",   64'(bus.data_out),   64'd0);
        chk("rst_sel",        64'(bus.sel),        64'd0);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_fail_count", 64'(bus.fail_count), 64'd0);
        chk("rst_locked",     64'(bus.locked),     64'd0);
        rst = 1'b0;
        tick();
        chk("rst_release_ready", 64'(bus.char_ready), 64'd1);

        for (int k = 0; k < 8; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            do_entry(vecs[k], tag);
            tick();
            chk({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
            chk({tag, "_data_hold"}, 64'(bus.data_out), 64'(vecs[k].exp_data));
            chk({tag, "_sel_hold"}, 64'(bus.sel), 64'(vecs[k].exp_sel));
            chk({tag, "_ready_back"}, 64'(bus.char_ready), 64'd1);
        end

        // Reset mid-entry discards partial characters.
        bus.char_in = 8'h39; bus.char_valid = 1'b1;
        tick();
        tick();
        bus.char_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_ready", 64'(bus.char_ready), 64'd0);
        chk("midrst_data",  64'(bus.data_out),   64'd0);
        rst = 1'b0;
        tick();
        do_entry(vecs[0], "after_midrst");
        tick();

        // Repeated failures.
        w = '{64'h39393939, 4, 1'b0, 8'h58, 1'b1, 3'd1};
`ifdef PASSWORD_LOCKOUT_EN
        for (int k = 1; k <= 3; k++) begin
            w.exp_fc = 3'(k);
            do_entry(w, $sformatf("lk_fail%0d", k));
            if (k < 3) tick();
        end
        for (int i = 0; i < 16; i++) begin
            bus.enter      = (i == 3);
            bus.char_valid = (i == 5);
            bus.char_in    = 8'h31;
            tick();
            chk($sformatf("lock_locked_%0d", i), 64'(bus.locked), 64'd1);
            chk($sformatf("lock_ready_%0d", i),  64'(bus.char_ready), 64'd0);
            chk($sformatf("lock_ov_%0d", i),     64'(bus.out_valid), 64'd0);
        end
        bus.enter      = 1'b0;
        bus.char_valid = 1'b0;
        tick();
        chk("unlock_locked", 64'(bus.locked),     64'd0);
        chk("unlock_fc",     64'(bus.fail_count), 64'd0);
        chk("unlock_ready",  64'(bus.char_ready), 64'd1);
        do_entry(vecs[0], "after_lock");
        tick();
`else
        for (int k = 1; k <= 4; k++) begin
            w.exp_fc = (k > 3) ? 3'd3 : 3'(k);
            do_entry(w, $sformatf("sat_fail%0d", k));
            tick();
            chk($sformatf("sat_ready%0d", k), 64'(bus.char_ready), 64'd1);
        end
        chk("sat_locked", 64'(bus.locked), 64'd0);
        do_entry(vecs[0], "after_sat");
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
